// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two cache clients, the main-RAM controller and ram_port_arbiter.
// The arbiter connects through the master modport; the environment connects through slave.
interface ram_port_arbiter_if #(
  parameter int unsigned address_space = 12,
  parameter int unsigned data_size     = 32
);

  logic                     c0_fetch;
  logic                     c0_flush;
  logic [address_space-1:0] c0_addr;
  logic [data_size-1:0]     c0_wdata;
  logic                     c0_fetch_ack;
  logic                     c0_flush_ack;

  logic                     c1_fetch;
  logic                     c1_flush;
  logic [address_space-1:0] c1_addr;
  logic [data_size-1:0]     c1_wdata;
  logic                     c1_fetch_ack;
  logic                     c1_flush_ack;

  logic [data_size-1:0]     c_rdata;

  logic                     ram_req;
  logic                     ram_we;
  logic [address_space-1:0] ram_addr;
  logic [data_size-1:0]     ram_wdata;
  logic [data_size-1:0]     ram_rdata;
  logic                     ram_ack;

  logic                     owner;
  logic                     busy;
  logic                     error;

  modport master (
    input  c0_fetch, c0_flush, c0_addr, c0_wdata,
    input  c1_fetch, c1_flush, c1_addr, c1_wdata,
    input  ram_rdata, ram_ack,
    output c0_fetch_ack, c0_flush_ack, c1_fetch_ack, c1_flush_ack, c_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata,
    output owner, busy, error
  );

  modport slave (
    output c0_fetch, c0_flush, c0_addr, c0_wdata,
    output c1_fetch, c1_flush, c1_addr, c1_wdata,
    output ram_rdata, ram_ack,
    input  c0_fetch_ack, c0_flush_ack, c1_fetch_ack, c1_flush_ack, c_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    input  owner, busy, error
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one main-RAM port between the I-cache (0) and D-cache (1).
// Optional macro ARB_TIMEOUT_EN adds a ram_ack watchdog and the sticky error flag.
module ram_port_arbiter #(
  parameter int unsigned address_space = 12,
  parameter int unsigned data_size     = 32,
  parameter int unsigned timeout       = 255
) (
  input logic                clka,
  input logic                rsta,
  ram_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StRespond} state_e;

  state_e                   state_q, state_d;
  logic                     last_q, last_d;
  logic                     owner_q, owner_d;
  logic                     busy_q, busy_d;
  logic                     error_q, error_d;
  logic                     ram_req_q, ram_req_d;
  logic                     ram_we_q, ram_we_d;
  logic [address_space-1:0] ram_addr_q, ram_addr_d;
  logic [data_size-1:0]     ram_wdata_q, ram_wdata_d;
  logic [data_size-1:0]     c_rdata_q, c_rdata_d;
  logic [1:0]               fetch_ack_q, fetch_ack_d;
  logic [1:0]               flush_ack_q, flush_ack_d;

  logic req0, req1, grant, win, win_we, expired, done;

  assign req0  = bus.c0_fetch | bus.c0_flush;
  assign req1  = bus.c1_fetch | bus.c1_flush;
  assign grant = req0 | req1;
  // On a tie the client that lost the previous grant wins.
  assign win    = (req0 & req1) ? ~last_q : req1;
  assign win_we = win ? bus.c1_flush : bus.c0_flush;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Counter is zero on entry to WAIT_ACK and advances once per waiting cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == StWaitAck) cnt_d = cnt_q + CntW'(1);
  end

  assign expired = (state_q == StWaitAck) && !bus.ram_ack && (cnt_q == CntW'(timeout - 1));
`else
  assign expired = 1'b0;
`endif

  assign done = (state_q == StWaitAck) && (bus.ram_ack || expired);

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant) state_d = StWaitAck;
      StWaitAck: if (done)  state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    error_d     = error_q | expired;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    c_rdata_d   = c_rdata_q;
    fetch_ack_d = 2'b00;
    flush_ack_d = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          ram_req_d   = 1'b1;
          ram_we_d    = win_we;
          ram_addr_d  = win ? bus.c1_addr : bus.c0_addr;
          ram_wdata_d = win ? bus.c1_wdata : bus.c0_wdata;
          owner_d     = win;
          last_d      = win;
          busy_d      = 1'b1;
        end
      end
      StWaitAck: begin
        if (done) begin
          ram_req_d = 1'b0;
          if (ram_we_q) begin
            flush_ack_d[owner_q] = 1'b1;
          end else begin
            fetch_ack_d[owner_q] = 1'b1;
            c_rdata_d            = expired ? '0 : bus.ram_rdata;
          end
        end
      end
      StRespond: busy_d = 1'b0;
      default: ;
    endcase
  end

  // last_q resets to 1 so client 0 wins the first tie.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      c_rdata_q   <= '0;
      fetch_ack_q <= 2'b00;
      flush_ack_q <= 2'b00;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      c_rdata_q   <= c_rdata_d;
      fetch_ack_q <= fetch_ack_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  assign bus.c0_fetch_ack = fetch_ack_q[0];
  assign bus.c1_fetch_ack = fetch_ack_q[1];
  assign bus.c0_flush_ack = flush_ack_q[0];
  assign bus.c1_flush_ack = flush_ack_q[1];
  assign bus.c_rdata      = c_rdata_q;
  assign bus.ram_req      = ram_req_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter; ack vector bits are
// {c1_flush, c1_fetch, c0_flush, c0_fetch}.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clka = 1'b0;
  logic rsta;
  int   checks = 0;
  int   errors = 0;

  always #5 clka = ~clka;

  ram_port_arbiter_if #(.address_space(AW), .data_size(DW)) bus ();

  ram_port_arbiter #(
    .address_space(AW),
    .data_size    (DW),
    .timeout      (TO)
  ) dut (
    .clka(clka),
    .rsta(rsta),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acks();
    return {28'd0, bus.c1_flush_ack, bus.c1_fetch_ack, bus.c0_flush_ack, bus.c0_fetch_ack};
  endfunction

  initial begin
    rsta          = 1'b0;
    bus.c0_fetch  = 1'b0;
    bus.c0_flush  = 1'b0;
    bus.c0_addr   = '0;
    bus.c0_wdata  = '0;
    bus.c1_fetch  = 1'b0;
    bus.c1_flush  = 1'b0;
    bus.c1_addr   = '0;
    bus.c1_wdata  = '0;
    bus.ram_rdata = '0;
    bus.ram_ack   = 1'b0;
    #2;
    chk("rst_req", 32'(bus.ram_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_acks", acks(), 32'd0);
    chk("rst_rdata", bus.c_rdata, 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    tick();
    tick();
    rsta = 1'b1;

    // Reset pulsed while a transaction is in WAIT_ACK.
    bus.c0_fetch = 1'b1;
    bus.c0_addr  = 12'h010;
    tick();
    chk("pre_rst_req", 32'(bus.ram_req), 32'd1);
    chk("pre_rst_addr", 32'(bus.ram_addr), 32'h010);
    #2 rsta = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.ram_req), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
    bus.c1_fetch = 1'b1;
    bus.c1_addr  = 12'h020;
    bus.ram_ack  = 1'b1;
    tick();
    chk("mid_rst_acks", acks(), 32'd0);
    bus.ram_ack = 1'b0;
    rsta        = 1'b1;
    tick();
    chk("tie_owner", 32'(bus.owner), 32'd0);
    chk("tie_addr", 32'(bus.ram_addr), 32'h010);
    chk("tie_req", 32'(bus.ram_req), 32'd1);
    bus.c1_fetch  = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h1357_9BDF;
    tick();
    chk("tie_acks", acks(), 32'd1);
    chk("tie_rdata", bus.c_rdata, 32'h1357_9BDF);
    bus.ram_ack  = 1'b0;
    bus.c0_fetch = 1'b0;
    tick();
    chk("tie_done_busy", 32'(bus.busy), 32'd0);
    chk("tie_done_acks", acks(), 32'd0);

    // c0 fetch at 0x123, RAM acks two cycles after the grant.
    bus.c0_fetch = 1'b1;
    bus.c0_addr  = 12'h123;
    bus.c0_wdata = 32'h0000_0077;
    tick();
    chk("f0_req", 32'(bus.ram_req), 32'd1);
    chk("f0_we", 32'(bus.ram_we), 32'd0);
    chk("f0_addr", 32'(bus.ram_addr), 32'h123);
    chk("f0_owner", 32'(bus.owner), 32'd0);
    chk("f0_busy", 32'(bus.busy), 32'd1);
    bus.c0_addr = 12'hFFF;
    tick();
    chk("f0_hold_addr", 32'(bus.ram_addr), 32'h123);
    chk("f0_hold_req", 32'(bus.ram_req), 32'd1);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hDEAD_BEEF;
    tick();
    chk("f0_acks", acks(), 32'd1);
    chk("f0_rdata", bus.c_rdata, 32'hDEAD_BEEF);
    chk("f0_req_drop", 32'(bus.ram_req), 32'd0);
    bus.ram_ack  = 1'b0;
    bus.c0_fetch = 1'b0;
    tick();
    chk("f0_ack_once", acks(), 32'd0);
    chk("f0_idle_busy", 32'(bus.busy), 32'd0);

    // ram_ack in IDLE with no request does nothing.
    bus.ram_ack = 1'b1;
    tick();
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);
    chk("idle_ack_acks", acks(), 32'd0);

    // c1 flush arriving together with a stray ram_ack in IDLE.
    bus.c1_flush  = 1'b1;
    bus.c1_addr   = 12'h0AB;
    bus.c1_wdata  = 32'h55AA_55AA;
    bus.ram_rdata = 32'h1111_1111;
    tick();
    chk("fl1_req", 32'(bus.ram_req), 32'd1);
    chk("fl1_we", 32'(bus.ram_we), 32'd1);
    chk("fl1_addr", 32'(bus.ram_addr), 32'h0AB);
    chk("fl1_wdata", bus.ram_wdata, 32'h55AA_55AA);
    chk("fl1_owner", 32'(bus.owner), 32'd1);
    tick();
    chk("fl1_acks", acks(), 32'd8);
    chk("fl1_rdata_kept", bus.c_rdata, 32'hDEAD_BEEF);
    bus.ram_ack  = 1'b0;
    bus.c1_flush = 1'b0;
    tick();
    chk("fl1_idle_busy", 32'(bus.busy), 32'd0);

    // Both clients request continuously: grants alternate 0,1,0,1.
    bus.c0_fetch = 1'b1;
    bus.c0_addr  = 12'h100;
    bus.c1_fetch = 1'b1;
    bus.c1_addr  = 12'h101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_owner", 32'(bus.owner), 32'(i % 2));
      chk("rr_addr", 32'(bus.ram_addr), 32'h100 + 32'(i % 2));
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'hA000_0000 + 32'(i);
      tick();
      chk("rr_acks", acks(), (i % 2 == 1) ? 32'd4 : 32'd1);
      chk("rr_rdata", bus.c_rdata, 32'hA000_0000 + 32'(i));
      bus.ram_ack = 1'b0;
      if (i == 3) begin
        bus.c0_fetch = 1'b0;
        bus.c1_fetch = 1'b0;
      end
      tick();
      chk("rr_idle_busy", 32'(bus.busy), 32'd0);
    end

    // c0 raises fetch and flush together: flush first, then fetch.
    bus.c0_fetch = 1'b1;
    bus.c0_flush = 1'b1;
    bus.c0_addr  = 12'h200;
    bus.c0_wdata = 32'hCAFE_F00D;
    tick();
    chk("ff_first_we", 32'(bus.ram_we), 32'd1);
    chk("ff_first_owner", 32'(bus.owner), 32'd0);
    chk("ff_first_wdata", bus.ram_wdata, 32'hCAFE_F00D);
    bus.ram_ack = 1'b1;
    tick();
    chk("ff_first_acks", acks(), 32'd2);
    bus.ram_ack  = 1'b0;
    bus.c0_flush = 1'b0;
    tick();
    tick();
    chk("ff_second_we", 32'(bus.ram_we), 32'd0);
    chk("ff_second_addr", 32'(bus.ram_addr), 32'h200);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0BAD_F00D;
    tick();
    chk("ff_second_acks", acks(), 32'd1);
    chk("ff_second_rdata", bus.c_rdata, 32'h0BAD_F00D);
    bus.ram_ack  = 1'b0;
    bus.c0_fetch = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // RAM never acks: watchdog fires after TO waiting cycles.
    bus.c0_fetch = 1'b1;
    bus.c0_addr  = 12'h003;
    tick();
    chk("to_req", 32'(bus.ram_req), 32'd1);
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      chk("to_wait_req", 32'(bus.ram_req), 32'd1);
      chk("to_wait_error", 32'(bus.error), 32'd0);
    end
    tick();
    chk("to_req_drop", 32'(bus.ram_req), 32'd0);
    chk("to_acks", acks(), 32'd1);
    chk("to_rdata", bus.c_rdata, 32'd0);
    chk("to_error", 32'(bus.error), 32'd1);
    bus.c0_fetch = 1'b0;
    tick();
    chk("to_idle_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("to_error_sticky", 32'(bus.error), 32'd1);
`else
    // Without the watchdog the arbiter waits indefinitely for ram_ack.
    bus.c0_fetch = 1'b1;
    bus.c0_addr  = 12'h003;
    tick();
    repeat (10) tick();
    chk("wait_req", 32'(bus.ram_req), 32'd1);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    chk("wait_acks", acks(), 32'd0);
    chk("wait_error", 32'(bus.error), 32'd0);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hA5A5_A5A5;
    tick();
    chk("wait_done_acks", acks(), 32'd1);
    chk("wait_done_rdata", bus.c_rdata, 32'hA5A5_A5A5);
    bus.ram_ack  = 1'b0;
    bus.c0_fetch = 1'b0;
    tick();
`endif

    // Final reset clears sticky state and read data.
    #2 rsta = 1'b0;
    #1;
    chk("end_rst_error", 32'(bus.error), 32'd0);
    chk("end_rst_rdata", bus.c_rdata, 32'd0);
    chk("end_rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rsta = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single main-RAM port between two cache clients: port 0 is the instruction cache and port 1 is the data cache. Each client raises `fetch` or `flush` and holds it until acknowledged. The arbiter picks one request with round-robin fairness, drives the RAM transaction, and returns a one-cycle `fetch_ack`/`flush_ack` to the owning client. It sits between the unified-cache instances and the on-board RAM controller.

## Interface
- `address_space`, 12, width of address buses
- `data_size`, 32, width of data buses
- `timeout`, 255, max cycles to wait for `ram_ack` (used only with ARB_TIMEOUT_EN)

- `clka`  in  1  clock, all logic on posedge
- `rsta`  in  1  reset; one clock; reset is asynchronous and active-low
- `c0_fetch`, `c1_fetch`  in  1  client read request, level, held until ack
- `c0_flush`, `c1_flush`  in  1  client write request, level, held until ack
- `c0_addr`, `c1_addr`  in  address_space  client address
- `c0_wdata`, `c1_wdata`  in  data_size  client write data
- `c0_fetch_ack`, `c1_fetch_ack`  out  1  one-cycle fetch completion
- `c0_flush_ack`, `c1_flush_ack`  out  1  one-cycle flush completion
- `c_rdata`  out  data_size  fetched data, shared; valid while any `fetch_ack` is high
- `ram_req`  out  1  RAM transaction request, level
- `ram_we`  out  1  1 = write (flush), 0 = read (fetch)
- `ram_addr`  out  address_space  latched address
- `ram_wdata`  out  data_size  latched write data
- `ram_rdata`  in  data_size  RAM read data, valid with `ram_ack`
- `ram_ack`  in  1  RAM completion, one cycle
- `owner`  out  1  client currently granted (valid while `busy`)
- `busy`  out  1  transaction in flight
- `error`  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT_ACK, RESPOND.
- IDLE:
  - A client is requesting if its `fetch|flush` is high.
  - One requester: it wins. Both requesting: the client that did not win the last grant wins. After reset, client 0 has priority.
  - Within one client, `flush` beats `fetch`.
  - On a win: latch addr, wdata and op into `ram_addr`, `ram_wdata`, `ram_we`. Set `ram_req=1`, `busy=1`, `owner`=winner, update the last-winner pointer. Go to WAIT_ACK.
- WAIT_ACK:
  - `ram_req`, `ram_addr`, `ram_wdata` and `ram_we` stay stable.
  - Client inputs are ignored, including the owner dropping its request.
  - On `ram_ack`: clear `ram_req`. For a read, capture `ram_rdata` into `c_rdata`. Go to RESPOND.
- RESPOND:
  - For exactly one cycle, assert `cN_fetch_ack` or `cN_flush_ack` for the owner, matching the latched op.
  - Next state is IDLE. `busy` clears when entering IDLE.
- `ram_ack` outside WAIT_ACK is ignored.
- `c_rdata` holds its last value until the next fetch completes.
- Reset, asserted in any state: go to IDLE; all outputs 0; `c_rdata`=0; pointer favours client 0; any in-flight transaction is abandoned with no ack.

## Timing
- All outputs are registered.
- Request high at edge k (arbiter in IDLE) -> `ram_req` high from edge k+1.
- `ram_ack` sampled at edge m -> `ram_req` low and client ack high from edge m+1, for one cycle -> IDLE from edge m+2.
- Minimum round-trip when RAM acks in the first WAIT_ACK cycle: request to ack in 3 cycles.
- A client drops its request on the edge after it sees the ack. The IDLE sample at m+3 therefore cannot re-grant a stale request.
- Back-to-back: the losing client is granted on the first IDLE sample after RESPOND, 2 cycles after the winner's ack.
- Simultaneous request arrival and `ram_ack` in IDLE: the ack is ignored and the request is granted.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_ACK and clears on entry.
  - If it reaches `timeout` without `ram_ack`: drop `ram_req`, go to RESPOND, ack the owner with `c_rdata`=0 for a fetch, and set `error`=1.
  - `error` clears only on reset.
- Not defined: no counter; WAIT_ACK waits indefinitely; `error` is tied to 0.

## Test plan
- Reset mid-WAIT_ACK: `ram_req`=1, `rsta` pulsed low -> all outputs 0 immediately, no client ack; after release, client 0 wins a tie.
- c0 fetch, addr 0x123, RAM acks 2 cycles later with 0xDEADBEEF -> `ram_we`=0, `ram_addr`=0x123, then one-cycle `c0_fetch_ack` with `c_rdata`=0xDEADBEEF.
- c1 flush, addr 0x0AB, data 0x55AA55AA -> `ram_we`=1 with latched values, then one-cycle `c1_flush_ack`; `c_rdata` unchanged.
- Both clients request continuously for 4 transactions -> grants alternate 0,1,0,1.
- c0 raises `fetch` and `flush` together -> flush is served first, then fetch on the next grant.
- ARB_TIMEOUT_EN, `timeout`=4, `ram_ack` never arrives -> `ram_req` drops after 4 WAIT_ACK cycles, `c0_fetch_ack` with `c_rdata`=0, `error`=1 stays until reset.
